// File: rtl/li_encoder_pkg.sv
// Shared definitions for the load-immediate encoder: MIPS I-type opcodes,
// encoding-kind codes, FSM state codes and an instruction-word builder.
package li_encoder_pkg;

  localparam logic [5:0]  OP_ORI   = 6'b001101;
  localparam logic [5:0]  OP_ADDIU = 6'b001001;
  localparam logic [5:0]  OP_LUI   = 6'b001111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [2:0] KIND_NOP    = 3'd0;
  localparam logic [2:0] KIND_ORI    = 3'd1;
  localparam logic [2:0] KIND_ADDIU  = 3'd2;
  localparam logic [2:0] KIND_LUI    = 3'd3;
  localparam logic [2:0] KIND_LUIORI = 3'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT1 = 2'd1;
  localparam logic [1:0] ST_EMIT2 = 2'd2;

  function automatic logic [31:0] itype(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/li_classify.sv
// Picks the shortest I-type encoding for loading imm32 into rt and builds
// the first word plus the ori follow-up used only by the two-word kind.
module li_classify
  import li_encoder_pkg::*;
#(
  parameter bit USE_ADDIU    = 1'b1,
  parameter bit DROP_ZERO_RT = 1'b1
) (
  input  logic [4:0]  rt,
  input  logic [31:0] imm32,
  output logic [2:0]  kind,
  output logic [31:0] word1,
  output logic [31:0] word2
);

  logic [15:0] hi_s;
  logic [15:0] lo_s;

  assign hi_s = imm32[31:16];
  assign lo_s = imm32[15:0];

  // First matching rule wins; the order below is the priority order.
  always_comb begin
    kind  = KIND_LUIORI;
    word1 = itype(OP_LUI, 5'd0, rt, hi_s);
    word2 = itype(OP_ORI, rt, rt, lo_s);
    if (DROP_ZERO_RT && (rt == 5'd0)) begin
      kind  = KIND_NOP;
      word1 = NOP_WORD;
    end else if (hi_s == 16'h0000) begin
      kind  = KIND_ORI;
      word1 = itype(OP_ORI, 5'd0, rt, lo_s);
    end else if (USE_ADDIU && (hi_s == {16{lo_s[15]}})) begin
      kind  = KIND_ADDIU;
      word1 = itype(OP_ADDIU, 5'd0, rt, lo_s);
    end else if (lo_s == 16'h0000) begin
      kind  = KIND_LUI;
      word1 = itype(OP_LUI, 5'd0, rt, hi_s);
    end else begin
      kind  = KIND_LUIORI;
      word1 = itype(OP_LUI, 5'd0, rt, hi_s);
    end
  end

endmodule

// File: rtl/li_encoder.sv
// Load-constant request to MIPS instruction-word stream encoder with
// valid/ready on both sides, one word per cycle, and a handed-off word counter.
module li_encoder
  import li_encoder_pkg::*;
#(
  parameter bit USE_ADDIU    = 1'b1,
  parameter bit DROP_ZERO_RT = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_rt,
  input  logic [31:0]      req_imm32,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins_instr,
  output logic             ins_last,
  output logic [CNT_W-1:0] enc_count
);

  logic [1:0]       state_r;
  logic [4:0]       rt_r;
  logic [31:0]      imm_r;
  logic [CNT_W-1:0] count_r;
  logic [2:0]       kind_s;
  logic [31:0]      word1_s;
  logic [31:0]      word2_s;
  logic             two_words_s;
  logic             fire_s;
  logic             accept_s;

  li_classify #(
    .USE_ADDIU    (USE_ADDIU),
    .DROP_ZERO_RT (DROP_ZERO_RT)
  ) u_classify (
    .rt    (rt_r),
    .imm32 (imm_r),
    .kind  (kind_s),
    .word1 (word1_s),
    .word2 (word2_s)
  );

  assign two_words_s = (kind_s == KIND_LUIORI);

  // Output word selection straight from the state and captured-request flops.
  always_comb begin
    ins_valid = 1'b0;
    ins_instr = 32'h0000_0000;
    ins_last  = 1'b0;
    case (state_r)
      ST_EMIT1: begin
        ins_valid = 1'b1;
        ins_instr = word1_s;
        ins_last  = ~two_words_s;
      end
      ST_EMIT2: begin
        ins_valid = 1'b1;
        ins_instr = word2_s;
        ins_last  = 1'b1;
      end
      default: begin
        ins_valid = 1'b0;
        ins_instr = 32'h0000_0000;
        ins_last  = 1'b0;
      end
    endcase
  end

  // A new request may overlap the final word's hand-off to keep 1 word/cycle.
  assign fire_s    = ins_valid & ins_ready;
  assign req_ready = (state_r == ST_IDLE) | (fire_s & ins_last);
  assign accept_s  = req_valid & req_ready;
  assign enc_count = count_r;

  // FSM, request capture and hand-off counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rt_r    <= 5'd0;
      imm_r   <= 32'h0000_0000;
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (fire_s) begin
        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (accept_s) begin
        state_r <= ST_EMIT1;
        rt_r    <= req_rt;
        imm_r   <= req_imm32;
      end else if (fire_s) begin
        case (state_r)
          ST_EMIT1: state_r <= two_words_s ? ST_EMIT2 : ST_IDLE;
          ST_EMIT2: state_r <= ST_IDLE;
          default:  state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_li_encoder.sv
// Self-checking bench: dut0 uses default parameters, dut1 disables addiu and
// zero-rt dropping and uses a 4-bit counter so wrap-around is reachable.
module tb_li_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        ins_valid [2];
  logic        ins_ready [2];
  logic        ins_last  [2];
  logic [31:0] ins_instr [2];
  logic [4:0]  req_rt;
  logic [31:0] req_imm32;
  logic [15:0] enc_count0;
  logic [3:0]  enc_count1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  li_encoder dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_rt(req_rt), .req_imm32(req_imm32),
    .ins_valid(ins_valid[0]), .ins_ready(ins_ready[0]),
    .ins_instr(ins_instr[0]), .ins_last(ins_last[0]),
    .enc_count(enc_count0)
  );

  li_encoder #(.USE_ADDIU(1'b0), .DROP_ZERO_RT(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_rt(req_rt), .req_imm32(req_imm32),
    .ins_valid(ins_valid[1]), .ins_ready(ins_ready[1]),
    .ins_instr(ins_instr[1]), .ins_last(ins_last[1]),
    .enc_count(enc_count1)
  );

  function automatic logic [15:0] cnt(input int d);
    return (d == 0) ? enc_count0 : {12'h000, enc_count1};
  endfunction

  function automatic logic [15:0] cmask(input int d);
    return (d == 0) ? 16'hFFFF : 16'h000F;
  endfunction

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input logic [31:0] imm);
    return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (imm % 32'd65536);
  endfunction

  // Reference: shortest encoding chosen from the numeric value of the constant.
  function automatic void model(input int d, input logic [4:0] rt, input logic [31:0] imm);
    bit use_addiu = (d == 0);
    bit drop_zero = (d == 0);
    int si = $signed(imm);
    exp_q.delete();
    if (drop_zero && rt == 5'd0)
      exp_q.push_back(32'h0000_0000);
    else if (imm < 32'd65536)
      exp_q.push_back(mk(13, 0, int'(rt), imm));
    else if (use_addiu && si >= -32768 && si <= 32767)
      exp_q.push_back(mk(9, 0, int'(rt), imm));
    else if (imm % 32'd65536 == 32'd0)
      exp_q.push_back(mk(15, 0, int'(rt), imm / 32'd65536));
    else begin
      exp_q.push_back(mk(15, 0, int'(rt), imm / 32'd65536));
      exp_q.push_back(mk(13, int'(rt), int'(rt), imm));
    end
  endfunction

  task automatic run_req(input int d, input logic [4:0] rt, input logic [31:0] imm,
                         input bit stall, input string name);
    logic [15:0] c0;
    logic        exp_last;
    int idx;
    int n;
    @(negedge clk);
    c0 = cnt(d);
    req_valid[d] = 1'b1; req_rt = rt; req_imm32 = imm; ins_ready[d] = 1'b1;
    #1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) begin
      failures++; $display("FAIL %s accept: req_ready never rose", name);
    end
    @(negedge clk);
    req_valid[d] = 1'b0; req_rt = 5'($urandom); req_imm32 = $urandom;
    idx = 0; n = 0;
    while (idx < exp_q.size() && n < 200) begin
      ins_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      exp_last = (idx == exp_q.size() - 1);
      checks++;
      if (ins_valid[d] !== 1'b1 || ins_instr[d] !== exp_q[idx] || ins_last[d] !== exp_last) begin
        failures++;
        $display("FAIL %s word%0d: got v=%b instr=%h last=%b expected v=1 instr=%h last=%b",
                 name, idx, ins_valid[d], ins_instr[d], ins_last[d], exp_q[idx], exp_last);
      end
      if (ins_ready[d]) idx++;
      @(negedge clk); n++;
    end
    ins_ready[d] = 1'b1;
    #1;
    checks++;
    if (n >= 200 || ins_valid[d] !== 1'b0 || cnt(d) !== ((c0 + 16'(exp_q.size())) & cmask(d))) begin
      failures++;
      $display("FAIL %s end: got v=%b count=%h expected v=0 count=%h", name, ins_valid[d], cnt(d),
               (c0 + 16'(exp_q.size())) & cmask(d));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ins_valid[d] !== 1'b0 || ins_instr[d] !== 32'h0 || ins_last[d] !== 1'b0 ||
          cnt(d) !== 16'h0 || req_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset dut%0d: got v=%b instr=%h last=%b count=%h rdy=%b expected 0/0/0/0/1",
                 d, ins_valid[d], ins_instr[d], ins_last[d], cnt(d), req_ready[d]);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_vectors();
    exp_q = '{32'h3408_1234};               run_req(0, 5'd8,  32'h0000_1234, 1'b0, "ori");
    exp_q = '{32'h2409_8000};               run_req(0, 5'd9,  32'hFFFF_8000, 1'b0, "addiu");
    exp_q = '{32'h3C09_FFFF, 32'h3529_8000}; run_req(1, 5'd9,  32'hFFFF_8000, 1'b0, "no_addiu");
    exp_q = '{32'h3C0A_1234, 32'h354A_5678}; run_req(0, 5'd10, 32'h1234_5678, 1'b0, "lui_ori");
    exp_q = '{32'h3C0A_1234};               run_req(0, 5'd10, 32'h1234_0000, 1'b0, "lui");
    exp_q = '{32'h0000_0000};               run_req(0, 5'd0,  32'hDEAD_BEEF, 1'b0, "nop_rt0");
    exp_q = '{32'h3C00_DEAD, 32'h3400_BEEF}; run_req(1, 5'd0,  32'hDEAD_BEEF, 1'b0, "keep_rt0");
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    @(negedge clk);
    c0 = cnt(0);
    req_valid[0] = 1'b1; req_rt = 5'd8; req_imm32 = 32'h0000_1234; ins_ready[0] = 1'b0;
    @(negedge clk);
    req_rt = 5'd3; req_imm32 = 32'h0000_0005;
    repeat (3) begin
      #1;
      checks++;
      if (ins_valid[0] !== 1'b1 || ins_instr[0] !== 32'h3408_1234 || ins_last[0] !== 1'b1 ||
          req_ready[0] !== 1'b0 || cnt(0) !== c0) begin
        failures++;
        $display("FAIL stall hold: got v=%b instr=%h last=%b rdy=%b count=%h expected 1/34081234/1/0/%h",
                 ins_valid[0], ins_instr[0], ins_last[0], req_ready[0], cnt(0), c0);
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0; ins_ready[0] = 1'b1;
    #1;
    checks++;
    if (ins_instr[0] !== 32'h3408_1234) begin
      failures++; $display("FAIL stall release: got instr=%h expected 34081234", ins_instr[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (ins_valid[0] !== 1'b0 || cnt(0) !== c0 + 16'd1) begin
      failures++;
      $display("FAIL stall count: got v=%b count=%h expected v=0 count=%h", ins_valid[0], cnt(0), c0 + 16'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rts  [4];
    logic [31:0] imms [4];
    logic [31:0] words[4];
    logic [15:0] c0;
    for (int k = 0; k < 4; k++) begin
      rts[k]  = 5'($urandom_range(1, 31));
      imms[k] = {16'h0000, 16'($urandom)};
      model(0, rts[k], imms[k]);
      words[k] = exp_q[0];
    end
    @(negedge clk);
    c0 = cnt(0);
    ins_ready[0] = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        req_valid[0] = 1'b1; req_rt = rts[k]; req_imm32 = imms[k];
      end else begin
        req_valid[0] = 1'b0;
      end
      #1;
      if (k > 0) begin
        checks++;
        if (ins_valid[0] !== 1'b1 || ins_instr[0] !== words[k-1] || req_ready[0] !== 1'b1) begin
          failures++;
          $display("FAIL b2b word%0d: got v=%b instr=%h rdy=%b expected 1/%h/1",
                   k - 1, ins_valid[0], ins_instr[0], req_ready[0], words[k-1]);
        end
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (ins_valid[0] !== 1'b0 || cnt(0) !== c0 + 16'd4) begin
      failures++;
      $display("FAIL b2b end: got v=%b count=%h expected v=0 count=%h", ins_valid[0], cnt(0), c0 + 16'd4);
    end
  endtask

  task automatic test_reset_mid_pair();
    @(negedge clk);
    req_valid[0] = 1'b1; req_rt = 5'd10; req_imm32 = 32'h1234_5678; ins_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ins_valid[0] !== 1'b1 || ins_instr[0] !== 32'h354A_5678) begin
      failures++;
      $display("FAIL pre_reset emit2: got v=%b instr=%h expected 1/354a5678", ins_valid[0], ins_instr[0]);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (ins_valid[0] !== 1'b0 || ins_instr[0] !== 32'h0 || cnt(0) !== 16'h0 || cnt(1) !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b instr=%h count0=%h count1=%h expected 0/0/0/0",
               ins_valid[0], ins_instr[0], cnt(0), cnt(1));
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ins_valid[0] !== 1'b0 || cnt(0) !== 16'h0) begin
      failures++;
      $display("FAIL after_reset: got v=%b count=%h expected 0/0", ins_valid[0], cnt(0));
    end
  endtask

  task automatic test_random();
    int d;
    logic [4:0]  rt;
    logic [31:0] imm;
    for (int i = 0; i < 40; i++) begin
      d  = $urandom_range(0, 1);
      rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 4))
        0:       imm = {16'h0000, 16'($urandom)};
        1:       imm = {16'hFFFF, 1'b1, 15'($urandom)};
        2:       imm = {16'($urandom), 16'h0000};
        3:       imm = {16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535))};
        default: imm = $urandom;
      endcase
      model(d, rt, imm);
      run_req(d, rt, imm, 1'b1, "random");
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    ins_ready[0] = 1'b1; ins_ready[1] = 1'b1;
    req_rt = 5'd0; req_imm32 = 32'h0;
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid_pair();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
